// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width and default receive FIFO geometry, so the
// receive stage and the FIFO agree on widths.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int FIFO_ADDR_W    = 4;
  localparam int FIFO_AFULL_LVL = 12;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM, synchronous write and registered synchronous read.
// Sized for the UART FIFOs; the read register resets, the array does not.
module uart_fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdData_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData_q <= '0;
    end else if (rd_en_i) begin
      rdData_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO behind the UART receiver: wrap-bit pointers, registered
// read port with a valid pulse, occupancy count, almost-full and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_write,
  output logic              data_in_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              afull,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic [ADDR_W:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0] rdPtr_q, rdPtr_d;
  logic            rdValid_q, rdValid_d;
  logic            overflow_q, overflow_d;

  logic            fullNow;
  logic            emptyNow;
  logic            wrAcc;
  logic            rdAcc;
  logic [ADDR_W:0] occupancy;

  // Full when the address bits match but the wrap bits differ.
  assign emptyNow  = (wrPtr_q == rdPtr_q);
  assign fullNow   = (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]) &&
                     (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]);
  assign occupancy = wrPtr_q - rdPtr_q;

  assign wrAcc = data_in_write & ~fullNow;
  assign rdAcc = rd_en & ~emptyNow;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    rdValid_d  = rdAcc;
    overflow_d = overflow_q;
    if (wrAcc) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAcc) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    // A dropped write outranks a simultaneous clear.
    if (data_in_write && fullNow) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      rdValid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      rdValid_q  <= rdValid_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wrAcc),
    .wr_addr_i (wrPtr_q[ADDR_W-1:0]),
    .wr_data_i (data_in),
    .rd_en_i   (rdAcc),
    .rd_addr_i (rdPtr_q[ADDR_W-1:0]),
    .rd_data_o (rd_data)
  );

  assign data_in_full = fullNow;
  assign empty        = emptyNow;
  assign count        = occupancy;
  assign afull        = (occupancy >= (ADDR_W + 1)'(AFULL_LVL));
  assign rd_valid     = rdValid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default 8-bit, 16-entry build).
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_in_write;
  logic       data_in_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       afull;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;

  int vectors;
  int errors;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_write (data_in_write),
    .data_in_full  (data_in_full),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .afull         (afull),
    .count         (count),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_in_write = 1'b0;
    rd_en         = 1'b0;
    ovf_clr       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    data_in = 8'h00;
    rst_n   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    vectors++; if (data_in_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", data_in_full); end
    vectors++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    vectors++; if (afull !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull got %b want 0", afull); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got %h want 00", rd_data); end
  endtask

  task automatic test_basic();
    logic [7:0] expData;
    for (int i = 0; i < 3; i++) begin
      data_in       = 8'h41 + 8'(i);
      data_in_write = 1'b1;
      tick();
    end
    data_in_write = 1'b0;
    vectors++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL basic_count3 got %0d want 3", count); end
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_valid got %b want 0", rd_valid); end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      expData = 8'h41 + 8'(i);
      vectors++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid[%0d] got %b want 1", i, rd_valid); end
      vectors++; if (rd_data !== expData) begin errors++; $display("[TB] FAIL basic_data[%0d] got %h want %h", i, rd_data, expData); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 8'h43) begin errors++; $display("[TB] FAIL basic_data_hold got %h want 43", rd_data); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL basic_empty got %b want 1", empty); end
    vectors++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL basic_count0 got %0d want 0", count); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      data_in       = 8'(i);
      data_in_write = 1'b1;
      tick();
      vectors++; if (count !== 5'(i + 1)) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      vectors++; if (afull !== (i + 1 >= 12)) begin errors++; $display("[TB] FAIL fill_afull[%0d] got %b want %b", i, afull, (i + 1 >= 12)); end
      vectors++; if (data_in_full !== (i + 1 == 16)) begin errors++; $display("[TB] FAIL fill_full[%0d] got %b want %b", i, data_in_full, (i + 1 == 16)); end
    end
    data_in = 8'hFF;
    tick();
    data_in_write = 1'b0;
    vectors++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
    vectors++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got %0d want 16", count); end
    // Overflow event and clear together: the set must win.
    data_in_write = 1'b1;
    ovf_clr       = 1'b1;
    tick();
    idle();
    vectors++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++; $display("[TB] FAIL fill_read[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'(i));
      end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_drained got e=%b v=%b want e=1 v=0", empty, rd_valid); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_simul_full();
    logic [7:0] expData;
    for (int i = 0; i < 16; i++) begin
      data_in       = 8'h10 + 8'(i);
      data_in_write = 1'b1;
      tick();
    end
    data_in = 8'hAA;
    rd_en   = 1'b1;
    tick();
    idle();
    vectors++; if (count !== 5'd15) begin errors++; $display("[TB] FAIL sfull_count got %0d want 15", count); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL sfull_overflow got %b want 1", overflow); end
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h10) begin errors++; $display("[TB] FAIL sfull_read got v=%b d=%h want v=1 d=10", rd_valid, rd_data); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sfull_ovf_clr got %b want 0", overflow); end
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      expData = 8'h10 + 8'(i);
      vectors++; if (rd_valid !== 1'b1 || rd_data !== expData) begin
        errors++; $display("[TB] FAIL sfull_drain[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, expData);
      end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL sfull_empty got %b want 1", empty); end
  endtask

  task automatic test_simul_empty();
    data_in       = 8'h5A;
    data_in_write = 1'b1;
    rd_en         = 1'b1;
    tick();
    data_in_write = 1'b0;
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL sempty_valid got %b want 0", rd_valid); end
    vectors++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL sempty_count got %0d want 1", count); end
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin errors++; $display("[TB] FAIL sempty_read got v=%b d=%h want v=1 d=5a", rd_valid, rd_data); end
    tick();
    vectors++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL sempty_after got v=%b e=%b want v=0 e=1", rd_valid, empty); end
  endtask

  task automatic test_stream_wrap();
    logic [7:0] expQ[$];
    logic [7:0] expData;
    int modelCount = 0;
    int wrIdx = 0;
    int rdIdx = 0;
    logic doWr;
    logic doRd;
    for (int cyc = 0; cyc < 300 && rdIdx < 40; cyc++) begin
      doWr = (wrIdx < 40) && (modelCount < 3);
      doRd = (modelCount > 0) && (modelCount >= 1 + (cyc % 3));
      data_in       = 8'h80 + 8'(wrIdx);
      data_in_write = doWr;
      rd_en         = doRd;
      tick();
      if (doWr) begin
        expQ.push_back(8'h80 + 8'(wrIdx));
        wrIdx++;
        modelCount++;
      end
      if (doRd) begin
        expData = expQ.pop_front();
        rdIdx++;
        modelCount--;
        vectors++; if (rd_valid !== 1'b1 || rd_data !== expData) begin
          errors++; $display("[TB] FAIL stream_read[%0d] got v=%b d=%h want v=1 d=%h", rdIdx - 1, rd_valid, rd_data, expData);
        end
      end else begin
        vectors++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_idle_valid cyc %0d got %b want 0", cyc, rd_valid); end
      end
      vectors++; if (count !== 5'(modelCount) || overflow !== 1'b0) begin
        errors++; $display("[TB] FAIL stream_count cyc %0d got c=%0d o=%b want c=%0d o=0", cyc, count, overflow, modelCount);
      end
    end
    idle();
    vectors++; if (rdIdx != 40) begin errors++; $display("[TB] FAIL stream_done got %0d bytes want 40", rdIdx); end

    for (int i = 0; i < 2; i++) begin
      data_in       = 8'hC0 + 8'(i);
      data_in_write = 1'b1;
      tick();
    end
    data_in_write = 1'b0;
    rd_en         = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b1 || count !== 5'd1) begin errors++; $display("[TB] FAIL midrst_pre got v=%b c=%0d want v=1 c=1", rd_valid, count); end
    rst_n = 1'b0;
    #2;
    vectors++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("[TB] FAIL midrst_flags got e=%b c=%0d want e=1 c=0", empty, count); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_read got v=%b d=%h want v=0 d=00", rd_valid, rd_data); end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (empty !== 1'b1 || data_in_full !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after got e=%b f=%b want e=1 f=0", empty, data_in_full); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_simul_full();
    test_simul_empty();
    test_stream_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
